forward_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 5-stage pipelined CPU. It keeps shadow copies of the register-write information for the ID/EX, EX/MEM and MEM/WB stages. From these it drives the 2-bit select codes of the two EX-stage 32-bit operand forwarding muxes. It also generates the load-use stall and the bubble and freeze controls for the datapath, and counts stall cycles for performance reporting.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/forward_hazard_ctrl_fwd_sel.sv | 20 ++
 rtl/forward_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the pipeline hazard logic: forwarding select codes,
// shadow-stage records and the per-cycle control mode.
package cpu_pkg;

    localparam int SHADOW_AW = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_FLUSH,
        CTRL_LU_STALL,
        CTRL_MEM_WAIT
    } ctrl_mode_t;

    // Register-write view of the instruction sitting in ID/EX.
    typedef struct packed {
        logic [SHADOW_AW-1:0] rs;
        logic [SHADOW_AW-1:0] rt;
        logic [SHADOW_AW-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } ex_shadow_t;

    // Register-write view of the instructions in EX/MEM and MEM/WB.
    typedef struct packed {
        logic [SHADOW_AW-1:0] rd;
        logic                 regwrite;
    } wr_shadow_t;

    // $0 is hard-wired to zero, so a write to it never produces a value to forward.
    function automatic logic writes_reg(wr_shadow_t s, logic [SHADOW_AW-1:0] addr);
        return s.regwrite && (s.rd != '0) && (s.rd == addr);
    endfunction

endpackage

// File: rtl/forward_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX operand: the youngest in-flight writer wins.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [SHADOW_AW-1:0] op_addr,
    input  wr_shadow_t           s_mem,
    input  wr_shadow_t           s_wb,
    output logic [1:0]           sel
);

    always_comb begin
        sel = FWD_REG;
        if (writes_reg(s_mem, op_addr)) begin
            sel = FWD_EXMEM;
        end else if (writes_reg(s_wb, op_addr)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding and hazard controller: shadows the register-write info of the
// back three stages, drives operand forwarding, load-use stall and freeze.
module forward_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              dmem_busy_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              idex_bubble_o,
    output logic              stall_all_o,
    output logic [CNT_W-1:0]  lu_stall_cnt_o,
    output logic [CNT_W-1:0]  mem_stall_cnt_o
);

    ex_shadow_t       s_ex_reg;
    ex_shadow_t       s_ex_next;
    wr_shadow_t       s_mem_reg;
    wr_shadow_t       s_wb_reg;
    logic [CNT_W-1:0] lu_cnt_reg;
    logic [CNT_W-1:0] mem_cnt_reg;

    ctrl_mode_t       mode;
    logic             lu_hazard;

    logic [SHADOW_AW-1:0] op_addr  [2];
    logic [1:0]           fwd_sel_w[2];

    assign op_addr[0] = s_ex_reg.rs;
    assign op_addr[1] = s_ex_reg.rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .op_addr (op_addr[gi]),
                .s_mem   (s_mem_reg),
                .s_wb    (s_wb_reg),
                .sel     (fwd_sel_w[gi])
            );
        end
    endgenerate

    assign fwd_a_sel_o = fwd_sel_w[0];
    assign fwd_b_sel_o = fwd_sel_w[1];

    // The load in EX has no data yet; a dependent reader in ID must wait one cycle.
    always_comb begin
        lu_hazard = s_ex_reg.memread && (s_ex_reg.rd != '0) &&
                    ((id_uses_rs_i && (id_rs_i == s_ex_reg.rd)) ||
                     (id_uses_rt_i && (id_rt_i == s_ex_reg.rd)));
    end

    always_comb begin
        if (dmem_busy_i) begin
            mode = CTRL_MEM_WAIT;
        end else if (flush_i) begin
            mode = CTRL_FLUSH;
        end else if (lu_hazard) begin
            mode = CTRL_LU_STALL;
        end else begin
            mode = CTRL_RUN;
        end
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        stall_all_o   = 1'b0;
        case (mode)
            CTRL_MEM_WAIT: begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                stall_all_o  = 1'b1;
            end
            CTRL_FLUSH: begin
                idex_bubble_o = 1'b1;
            end
            CTRL_LU_STALL: begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
            end
            default: ;
        endcase
    end

    // A bubble clears memread, which is what ends a load-use stall after one cycle.
    always_comb begin
        s_ex_next = '0;
        if (!idex_bubble_o) begin
            s_ex_next.rs       = id_rs_i;
            s_ex_next.rt       = id_rt_i;
            s_ex_next.rd       = id_rd_i;
            s_ex_next.regwrite = id_regwrite_i;
            s_ex_next.memread  = id_memread_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_ex_reg  <= '0;
            s_mem_reg <= '0;
            s_wb_reg  <= '0;
        end else if (mode != CTRL_MEM_WAIT) begin
            s_wb_reg           <= s_mem_reg;
            s_mem_reg.rd       <= s_ex_reg.rd;
            s_mem_reg.regwrite <= s_ex_reg.regwrite;
            s_ex_reg           <= s_ex_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lu_cnt_reg  <= '0;
            mem_cnt_reg <= '0;
        end else begin
            if ((mode == CTRL_LU_STALL) && (lu_cnt_reg != '1)) begin
                lu_cnt_reg <= lu_cnt_reg + 1'b1;
            end
            if ((mode == CTRL_MEM_WAIT) && (mem_cnt_reg != '1)) begin
                mem_cnt_reg <= mem_cnt_reg + 1'b1;
            end
        end
    end

    assign lu_stall_cnt_o  = lu_cnt_reg;
    assign mem_stall_cnt_o = mem_cnt_reg;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Self-checking bench for forward_hazard_ctrl: directed program fragments
// followed by random traffic, compared against an instruction-queue model.
module tb_forward_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs_i, id_rt_i, id_rd_i;
    logic             id_uses_rs_i, id_uses_rt_i, id_regwrite_i, id_memread_i;
    logic             flush_i, dmem_busy_i;
    logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
    logic             pc_write_o, ifid_write_o, idex_bubble_o, stall_all_o;
    logic [CNT_W-1:0] lu_stall_cnt_o, mem_stall_cnt_o;

    forward_hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .id_rs_i         (id_rs_i),
        .id_rt_i         (id_rt_i),
        .id_uses_rs_i    (id_uses_rs_i),
        .id_uses_rt_i    (id_uses_rt_i),
        .id_rd_i         (id_rd_i),
        .id_regwrite_i   (id_regwrite_i),
        .id_memread_i    (id_memread_i),
        .flush_i         (flush_i),
        .dmem_busy_i     (dmem_busy_i),
        .fwd_a_sel_o     (fwd_a_sel_o),
        .fwd_b_sel_o     (fwd_b_sel_o),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .idex_bubble_o   (idex_bubble_o),
        .stall_all_o     (stall_all_o),
        .lu_stall_cnt_o  (lu_stall_cnt_o),
        .mem_stall_cnt_o (mem_stall_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: an in-order list of instructions, index 0 = in EX, 1 = in MEM, 2 = in WB.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    ins_t pipe[$];
    int   m_lu;
    int   m_mem;
    logic [1:0] e_a, e_b;
    logic       e_pc, e_ifid, e_bub, e_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nearest older instruction that writes the register supplies the value.
    function automatic logic [1:0] ref_fwd(input logic [4:0] a);
        for (int d = 1; d <= 2; d++) begin
            if (pipe[d].rw && pipe[d].rd != 5'd0 && pipe[d].rd == a)
                return (d == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        ins_t ex = pipe[0];
        return ex.mr && ex.rd != 5'd0 &&
               ((id_uses_rs_i && id_rs_i == ex.rd) || (id_uses_rt_i && id_rt_i == ex.rd));
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back('0);
        m_lu  = 0;
        m_mem = 0;
    endtask

    task automatic model_eval();
        e_a = ref_fwd(pipe[0].rs);
        e_b = ref_fwd(pipe[0].rt);
        if (dmem_busy_i)  {e_pc, e_ifid, e_bub, e_stall} = 4'b0001;
        else if (flush_i) {e_pc, e_ifid, e_bub, e_stall} = 4'b1110;
        else if (ref_lu()) {e_pc, e_ifid, e_bub, e_stall} = 4'b0010;
        else              {e_pc, e_ifid, e_bub, e_stall} = 4'b1100;
    endtask

    task automatic model_adv();
        bit lu;
        lu = ref_lu();
        if (dmem_busy_i) begin
            if (m_mem < CNT_MAX) m_mem++;
        end else begin
            if (lu && !flush_i && m_lu < CNT_MAX) m_lu++;
            if (flush_i || lu) pipe.push_front('0);
            else pipe.push_front({id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i});
            void'(pipe.pop_back());
        end
    endtask

    task automatic check_all();
        chk("fwd_a",       32'(fwd_a_sel_o),     32'(e_a));
        chk("fwd_b",       32'(fwd_b_sel_o),     32'(e_b));
        chk("pc_write",    32'(pc_write_o),      32'(e_pc));
        chk("ifid_write",  32'(ifid_write_o),    32'(e_ifid));
        chk("idex_bubble", 32'(idex_bubble_o),   32'(e_bub));
        chk("stall_all",   32'(stall_all_o),     32'(e_stall));
        chk("lu_cnt",      32'(lu_stall_cnt_o),  32'(m_lu));
        chk("mem_cnt",     32'(mem_stall_cnt_o), 32'(m_mem));
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] rd, input logic rw, input logic mr);
        id_rs_i = rs; id_rt_i = rt; id_uses_rs_i = urs; id_uses_rt_i = urt;
        id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr;
        flush_i = 1'b0; dmem_busy_i = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] base);
        set_id(base, rd, 1'b1, 1'b0, rd, 1'b1, 1'b1);
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(negedge clk);
        model_eval();
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic step();
        cyc();
        adv();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        model_reset();
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        #2 rst_i = 1'b1;
    endtask

    initial begin
        nop();
        do_reset();

        // Back-to-back ALU dependency on rs -> EX/MEM forward.
        alu(5'd3, 5'd1, 5'd2); step();
        alu(5'd4, 5'd3, 5'd5); step();
        nop(); cyc();
        chk("tp1_fwd_a", 32'(fwd_a_sel_o), 32'h2);
        adv();

        // One instruction apart on rt -> MEM/WB forward.
        alu(5'd3, 5'd1, 5'd2); step();
        nop(); step();
        alu(5'd4, 5'd5, 5'd3); step();
        nop(); cyc();
        chk("tp2_fwd_b", 32'(fwd_b_sel_o), 32'h1);
        adv();

        // Both MEM and WB write $3: the younger one wins.
        alu(5'd3, 5'd1, 5'd2); step();
        alu(5'd3, 5'd6, 5'd7); step();
        alu(5'd4, 5'd5, 5'd3); step();
        nop(); cyc();
        chk("tp2_prio", 32'(fwd_b_sel_o), 32'h2);
        adv();

        // Load-use: one stall cycle, then MEM/WB forwarding on both operands.
        do_reset();
        lw(5'd2, 5'd1); step();
        alu(5'd6, 5'd2, 5'd2); cyc();
        chk("tp3_pc_write", 32'(pc_write_o), 32'h0);
        chk("tp3_ifid",     32'(ifid_write_o), 32'h0);
        chk("tp3_bubble",   32'(idex_bubble_o), 32'h1);
        adv();
        cyc(); adv();
        nop(); cyc();
        chk("tp3_fwd_a",  32'(fwd_a_sel_o), 32'h1);
        chk("tp3_fwd_b",  32'(fwd_b_sel_o), 32'h1);
        chk("tp3_lu_cnt", 32'(lu_stall_cnt_o), 32'h1);
        adv();

        // Writes to $0 never forward and loads to $0 never stall.
        alu(5'd0, 5'd1, 5'd2); step();
        alu(5'd7, 5'd0, 5'd0); step();
        nop(); cyc();
        chk("tp4_fwd_a", 32'(fwd_a_sel_o), 32'h0);
        chk("tp4_fwd_b", 32'(fwd_b_sel_o), 32'h0);
        adv();
        lw(5'd0, 5'd1); step();
        alu(5'd7, 5'd0, 5'd0); cyc();
        chk("tp4_no_lu", 32'(pc_write_o), 32'h1);
        adv();

        // Memory busy for 3 cycles over a lw/use pair; flush during busy is ignored.
        do_reset();
        alu(5'd1, 5'd3, 5'd4); step();
        lw(5'd2, 5'd1); step();
        for (int i = 0; i < 3; i++) begin
            alu(5'd6, 5'd2, 5'd2);
            dmem_busy_i = 1'b1;
            flush_i     = (i == 1);
            cyc();
            chk("tp5_stall_all", 32'(stall_all_o), 32'h1);
            chk("tp5_hold_a",    32'(fwd_a_sel_o), 32'h2);
            chk("tp5_no_bubble", 32'(idex_bubble_o), 32'h0);
            adv();
        end
        alu(5'd6, 5'd2, 5'd2); cyc();
        chk("tp5_mem_cnt", 32'(mem_stall_cnt_o), 32'h3);
        chk("tp5_lu_after", 32'(idex_bubble_o), 32'h1);
        adv();
        step();

        // Reset asserted in the middle of a load-use stall.
        lw(5'd2, 5'd1); step();
        alu(5'd6, 5'd2, 5'd2); cyc();
        chk("tp6_pre_stall", 32'(pc_write_o), 32'h0);
        #2 rst_i = 1'b0;
        model_reset();
        #1;
        model_eval();
        check_all();
        chk("tp6_pc_write", 32'(pc_write_o), 32'h1);
        chk("tp6_bubble",   32'(idex_bubble_o), 32'h0);
        chk("tp6_lu_cnt",   32'(lu_stall_cnt_o), 32'h0);
        @(posedge clk);
        #2 rst_i = 1'b1;
        nop(); step();

        // Random traffic with a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 2) == 0));
            flush_i     = ($urandom_range(0, 7) == 0);
            dmem_busy_i = ($urandom_range(0, 4) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
